// File: rtl/ram_arbiter.sv
// ram_arbiter: schedules the single RAM port among per-CPU icache/dcache requesters.
// Data wins over instruction, round-robin among CPUs, with an instruction anti-starvation count.
module ram_arbiter #(
    parameter int CPUS         = 2,
    parameter int BURST        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [1:0]           ramstate,
    input  logic [31:0]          ramload
);
    localparam int OW = CPUS > 1 ? $clog2(CPUS) : 1;
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [1:0] IDLE = 2'd0, IGRANT = 2'd1, DGRANT = 2'd2;
    localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, iptr_q, iptr_d, dptr_q, dptr_d, iwin, dwin;
    logic [BW-1:0] beat_q, beat_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wr_q, wr_d;
    logic [CPUS-1:0] dreq;
    logic          dgo, ig, dg, acc, ifirst;

    // Downward scan so the requester closest to ptr is the last (winning) assignment.
    function automatic logic [OW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [OW-1:0] ptr);
        rr_pick = ptr;
        for (int k = CPUS - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % CPUS]) rr_pick = OW'((int'(ptr) + k) % CPUS);
    endfunction

    function automatic logic [OW-1:0] inc(input logic [OW-1:0] v);
        inc = OW'((int'(v) + 1) % CPUS);
    endfunction

    assign dreq   = dREN | dWEN;
    assign iwin   = rr_pick(iREN, iptr_q);
    assign dwin   = rr_pick(dreq, dptr_q);
    assign ifirst = (|iREN) && (starve_q == SW'(STARVE_LIMIT) || !(|dreq));
    assign dgo    = wr_q ? dWEN[owner_q] : dREN[owner_q];
    assign acc    = ramstate == ACCESS;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            beat_q   <= '0;
            wr_q     <= 1'b0;
            iptr_q   <= '0;
            dptr_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beat_q   <= beat_d;
            wr_q     <= wr_d;
            iptr_q   <= iptr_d;
            dptr_q   <= dptr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        wr_d     = wr_q;
        iptr_d   = iptr_q;
        dptr_d   = dptr_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (ifirst) begin
                    state_d  = IGRANT;
                    owner_d  = iwin;
                    iptr_d   = inc(iwin);
                    starve_d = '0;
                end else if (|dreq) begin
                    state_d  = DGRANT;
                    owner_d  = dwin;
                    wr_d     = dWEN[dwin];
                    beat_d   = '0;
                    dptr_d   = inc(dwin);
                    starve_d = !(|iREN) ? '0 : starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1);
                end
            end
            IGRANT: state_d = (!iREN[owner_q] || acc || ramstate == ERROR) ? IDLE : IGRANT;
            DGRANT: begin
                if (!dgo || ramstate == ERROR) state_d = IDLE;
                else if (acc) begin
                    beat_d  = beat_q + BW'(1);
                    state_d = beat_q == BW'(BURST - 1) ? IDLE : DGRANT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ig       = state_q == IGRANT && iREN[owner_q];
        dg       = state_q == DGRANT && dgo;
        ramREN   = ig | (dg & ~wr_q);
        ramWEN   = dg & wr_q;
        ramaddr  = ig ? iaddr[32*owner_q +: 32] : dg ? daddr[32*owner_q +: 32] : '0;
        ramstore = (dg & wr_q) ? dstore[32*owner_q +: 32] : '0;
        iwait    = ~((ig & acc) ? CPUS'(1) << owner_q : '0);
        dwait    = ~((dg & acc) ? CPUS'(1) << owner_q : '0);
        iload    = {CPUS{ramload}};
        dload    = {CPUS{ramload}};
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors with hand-computed expectations for ram_arbiter.
module tb_ram_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    localparam logic [5:0] IDL = 6'b00_11_11;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait, ramstate;
    logic [63:0] iaddr, daddr, dstore, iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    int checks = 0, errors = 0;
    int seq [29] = '{0, 1,1,0,1,1,0,1,1,0,1,1,0,2,0, 1,1,0,1,1,0,1,1,0,1,1,0,2,0};
    int ip;

    always #5 CLK = ~CLK;

    ram_arbiter dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramstate(ramstate), .ramload(ramload)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ctl = {ramREN, ramWEN, iwait[1:0], dwait[1:0]}
    task automatic bus(input string tag, input logic [5:0] ctl, input logic [31:0] addr);
        chk({tag, " ctl"}, {26'd0, ramREN, ramWEN, iwait, dwait}, {26'd0, ctl});
        chk({tag, " addr"}, ramaddr, addr);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic quiet();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramstate = FREE;
    endtask

    task automatic do_reset();
        quiet();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        quiet();
        ramload = 32'hdeadbeef;
        #1;
        bus("reset", IDL, 32'h0);
        chk("reset store", ramstore, 32'h0);
        chk("reset dload", dload[31:0], 32'hdeadbeef);
        chk("reset iload", iload[63:32], 32'hdeadbeef);

        do_reset();
        dWEN = 2'b01; daddr[31:0] = 32'h100; dstore[31:0] = 32'haaaa0001; ramstate = ACCESS;
        #1; bus("wr idle", IDL, 32'h0);
        tick(); #1;
        bus("wr b0", 6'b01_11_10, 32'h100);
        chk("wr b0 store", ramstore, 32'haaaa0001);
        tick(); daddr[31:0] = 32'h104; dstore[31:0] = 32'haaaa0002; #1;
        bus("wr b1", 6'b01_11_10, 32'h104);
        chk("wr b1 store", ramstore, 32'haaaa0002);
        tick(); dWEN = 2'b00; #1;
        bus("wr done", IDL, 32'h0);

        do_reset();
        dREN = 2'b11; daddr = {32'h300, 32'h200}; dstore = {32'h5, 32'h7}; ramstate = ACCESS;
        for (int g = 0; g < 4; g++) begin
            #1; bus($sformatf("rr idle g%0d", g), IDL, 32'h0);
            tick(); #1;
            bus($sformatf("rr b0 g%0d", g), {4'b10_11, g % 2 ? 2'b01 : 2'b10}, g % 2 ? 32'h300 : 32'h200);
            chk("rr read store", ramstore, 32'h0);
            tick(); #1;
            bus($sformatf("rr b1 g%0d", g), {4'b10_11, g % 2 ? 2'b01 : 2'b10}, g % 2 ? 32'h300 : 32'h200);
            tick();
        end
        dREN = 2'b00;

        do_reset();
        iREN = 2'b10; iaddr = {32'h80, 32'h0}; dWEN = 2'b01; daddr[31:0] = 32'h500; ramstate = ACCESS;
        ip = 0;
        for (int c = 0; c < 29; c++) begin
            #1;
            if (seq[c] == 0) bus($sformatf("starve c%0d", c), IDL, 32'h0);
            else if (seq[c] == 1) bus($sformatf("starve c%0d", c), 6'b01_11_10, 32'h500);
            else bus($sformatf("starve c%0d", c), 6'b10_01_11, 32'h80);
            if (!iwait[1]) ip++;
            tick();
        end
        chk("starve ipulses", ip, 2);

        do_reset();
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = BUSY; ramload = 32'h12345678;
        #1; bus("ibusy idle", IDL, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1; bus($sformatf("ibusy k%0d", k), 6'b10_11_11, 32'h40);
            tick();
        end
        ramstate = ACCESS; #1;
        bus("iacc", 6'b10_10_11, 32'h40);
        chk("iacc iload", iload[31:0], 32'h12345678);
        tick(); iREN = 2'b00; ramstate = FREE; #1;
        bus("iacc done", IDL, 32'h0);

        do_reset();
        dREN = 2'b10; daddr = {32'h600, 32'h0}; ramstate = ACCESS;
        #1; bus("wd idle0", IDL, 32'h0);
        tick(); #1; bus("wd b0", 6'b10_11_01, 32'h600);
        tick(); dREN = 2'b00; #1; bus("wd drop", IDL, 32'h0);
        tick(); dREN = 2'b10; #1; bus("wd idle1", IDL, 32'h0);
        tick(); #1; bus("wd rg b0", 6'b10_11_01, 32'h600);
        tick(); #1; bus("wd rg b1", 6'b10_11_01, 32'h600);
        tick(); dREN = 2'b00; #1; bus("wd done", IDL, 32'h0);

        do_reset();
        dWEN = 2'b01; daddr[31:0] = 32'h700; ramstate = ACCESS;
        #1; bus("err idle0", IDL, 32'h0);
        tick(); ramstate = ERROR; #1; bus("err beat", 6'b01_11_11, 32'h700);
        tick(); ramstate = ACCESS; #1; bus("err idle1", IDL, 32'h0);
        tick(); #1; bus("err rg b0", 6'b01_11_10, 32'h700);
        tick(); #1; bus("err rg b1", 6'b01_11_10, 32'h700);
        tick(); dWEN = 2'b00; #1; bus("err done", IDL, 32'h0);

        do_reset();
        dREN = 2'b01; daddr[31:0] = 32'h800; ramstate = BUSY;
        #1; bus("ar idle", IDL, 32'h0);
        tick(); #1; bus("ar grant", 6'b10_11_11, 32'h800);
        #1; nRST = 1'b0;
        #1; bus("ar async", IDL, 32'h0);
        tick(); nRST = 1'b1; #1;
        bus("ar post idle", IDL, 32'h0);
        tick(); #1; bus("ar regrant", 6'b10_11_11, 32'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
